// File: rtl/mem_req_arbiter.sv
// Arbitrates N_PORTS cache-side memory requests onto a single AXI-facing request
// channel, one transaction at a time, using round-robin or fixed-priority selection.
module mem_req_arbiter #(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1,
    localparam int GW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_access,
    input  logic [N_PORTS-1:0]          req_write,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS*2-1:0]        req_size,
    input  logic [N_PORTS*4-1:0]        req_sel,
    input  logic [N_PORTS*DATA_W-1:0]   req_st_data,
    output logic [N_PORTS-1:0]          req_ready,
    output logic [DATA_W-1:0]           req_rdata,
    output logic [ADDR_W-1:0]           mem_a,
    output logic                        mem_access,
    output logic                        mem_write,
    output logic [1:0]                  mem_size,
    output logic [3:0]                  mem_sel,
    output logic [DATA_W-1:0]           mem_st_data,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_data,
    output logic [GW-1:0]               grant,
    output logic                        busy
);

    // Handshake: a port holds req_access with stable fields until it is sampled in IDLE;
    // mem_access stays high with a frozen request until the one-cycle mem_ready pulse,
    // which is forwarded in the same cycle as req_ready[grant].
    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_next;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       win;
    logic                found;
    logic [GW:0]         cand;
    logic                take;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_write;
    logic [1:0]          sel_size;
    logic [3:0]          sel_sel;
    logic [DATA_W-1:0]   sel_data;

    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        if (RR_MODE != 0) begin
            // Rotating search starting just after the previous owner.
            for (int k = 1; k <= N_PORTS; k++) begin
                cand = {1'b0, last_grant} + (GW+1)'(k);
                if (cand >= (GW+1)'(N_PORTS)) cand = cand - (GW+1)'(N_PORTS);
                if (!found && req_access[cand[GW-1:0]]) begin
                    win   = cand[GW-1:0];
                    found = 1'b1;
                end
            end
        end else begin
            for (int p = N_PORTS - 1; p >= 0; p--) begin
                if (req_access[p]) begin
                    win   = p[GW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_sel   = '0;
        sel_data  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (win == p[GW-1:0]) begin
                sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
                sel_write = req_write[p];
                sel_size  = req_size[p*2 +: 2];
                sel_sel   = req_sel[p*4 +: 4];
                sel_data  = req_st_data[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    take       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= GW'(N_PORTS - 1);
            mem_a       <= '0;
            mem_write   <= 1'b0;
            mem_size    <= '0;
            mem_sel     <= '0;
            mem_st_data <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                grant       <= win;
                last_grant  <= win;
                mem_a       <= sel_addr;
                mem_write   <= sel_write;
                mem_size    <= sel_size;
                mem_sel     <= sel_sel;
                mem_st_data <= sel_data;
            end
        end
    end

    assign busy       = (state == BUSY);
    assign mem_access = busy;
    assign req_rdata  = mem_data;

    always_comb begin
        req_ready = '0;
        if (busy && mem_ready) req_ready[grant] = 1'b1;
    end

endmodule
